// File: rtl/console_pkg.sv
// Shared constants and state encoding for the text console writer.
// ASCII control codes recognised by the writer, plus the FSM state enum.
// Scroll states exist only when CONSOLE_SCROLL_EN is defined.
package console_pkg;

  localparam logic [7:0] CHAR_BS    = 8'h08;
  localparam logic [7:0] CHAR_LF    = 8'h0A;
  localparam logic [7:0] CHAR_FF    = 8'h0C;
  localparam logic [7:0] CHAR_CR    = 8'h0D;
  localparam logic [7:0] CHAR_BLANK = 8'h20;

  // The newline action has no state of its own: it is resolved on the
  // edge that leaves IDLE (LF) or PUT (wrap), so a wrap on the last row
  // goes straight from PUT to SCR_RD.
  typedef enum logic [2:0] {
    IDLE,
    PUT,
    CLEAR
`ifdef CONSOLE_SCROLL_EN
    ,
    SCR_RD,
    SCR_WR,
    SCR_CLR
`endif
  } state_t;

endpackage

// File: rtl/console_cursor.sv
// Cursor position register: column/row with advance, CR, backspace, newline,
// bottom-row and home controls; outputs edge flags and the cell address.
// Latency: controls take effect on the next edge; address is combinational.
// Ports: clk_i/rst_ni clock+async reset; adv_i/cr_i/bs_i column controls;
//        nl_i/bottom_i/home_i row controls; col_o/row_o position;
//        last_col_o/last_row_o edge flags; addr_o = row*cols + col.
module console_cursor #(
  parameter int cols       = 40,
  parameter int rows       = 30,
  parameter int addr_width = $clog2(rows * cols)
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      adv_i,
  input  logic                      cr_i,
  input  logic                      bs_i,
  input  logic                      nl_i,
  input  logic                      bottom_i,
  input  logic                      home_i,
  output logic [$clog2(cols)-1:0]   col_o,
  output logic [$clog2(rows)-1:0]   row_o,
  output logic                      last_col_o,
  output logic                      last_row_o,
  output logic [addr_width-1:0]     addr_o
);

  localparam int CW = $clog2(cols);
  localparam int RW = $clog2(rows);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;

  assign last_col_o = (col_q == CW'(cols - 1));
  assign last_row_o = (row_q == RW'(rows - 1));

  always_comb begin
    col_d = col_q;
    if (home_i || cr_i) begin
      col_d = '0;
    end else if (adv_i) begin
      col_d = col_q + CW'(1);
    end else if (bs_i) begin
      col_d = col_q - CW'(1);
    end

    row_d = row_q;
    if (home_i) begin
      row_d = '0;
    end else if (bottom_i) begin
      row_d = RW'(rows - 1);
    end else if (nl_i) begin
      // Only reaches the last-row case when scrolling is not built in.
      row_d = last_row_o ? '0 : row_q + RW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign col_o  = col_q;
  assign row_o  = row_q;
  assign addr_o = addr_width'(row_q) * addr_width'(cols) + addr_width'(col_q);

endmodule

// File: rtl/console_writer.sv
// Character-stream front end: turns ASCII bytes into text-RAM write cycles.
// Latency: printable/BS 2 cycles, CR/LF/ignored 1, clear rows*cols, scroll
// 2*(rows-1)*cols+cols. Backpressure: in_ready low whenever state != IDLE.
// Ports: clk/rst_n; in_valid/in_data/in_ready byte input; ram_we/ram_addr/
//        ram_din/ram_dout single-port RAM; cursor_col/cursor_row; busy.
// Build option: define CONSOLE_SCROLL_EN to scroll on a last-row newline
// instead of wrapping to row 0.
module console_writer
  import console_pkg::*;
#(
  parameter int         cols       = 40,
  parameter int         rows       = 30,
  parameter int         addr_width = $clog2(rows * cols),
  parameter int         data_width = 8,
  parameter logic [7:0] BLANK      = CHAR_BLANK
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic [7:0]              in_data,
  output logic                    in_ready,
  output logic                    ram_we,
  output logic [addr_width-1:0]   ram_addr,
  output logic [data_width-1:0]   ram_din,
  input  logic [data_width-1:0]   ram_dout,
  output logic [$clog2(cols)-1:0] cursor_col,
  output logic [$clog2(rows)-1:0] cursor_row,
  output logic                    busy
);

  localparam logic [addr_width-1:0] LAST_CELL = addr_width'(rows * cols - 1);
`ifdef CONSOLE_SCROLL_EN
  localparam logic [addr_width-1:0] LAST_COPY = addr_width'((rows - 1) * cols - 1);
`else
  // Without scrolling the RAM is never read back.
  logic unused_dout;
  assign unused_dout = ^ram_dout;
`endif

  state_t                state_q, state_d;
  logic [addr_width-1:0] idx_q, idx_d;
  logic [7:0]            char_q, char_d;
  logic                  adv_q, adv_d;   // PUT came from a printable byte

  logic adv, cr, bs, nl, bottom, home, nl_req;
  logic last_col, last_row;
  logic [addr_width-1:0] cell_addr;

  console_cursor #(
    .cols       (cols),
    .rows       (rows),
    .addr_width (addr_width)
  ) u_cursor (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .adv_i      (adv),
    .cr_i       (cr),
    .bs_i       (bs),
    .nl_i       (nl),
    .bottom_i   (bottom),
    .home_i     (home),
    .col_o      (cursor_col),
    .row_o      (cursor_row),
    .last_col_o (last_col),
    .last_row_o (last_row),
    .addr_o     (cell_addr)
  );

  assign in_ready = (state_q == IDLE);
  assign busy     = (state_q != IDLE);

  // Next-state, counter and cursor-control decode.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    char_d  = char_q;
    adv_d   = adv_q;
    adv     = 1'b0;
    cr      = 1'b0;
    bs      = 1'b0;
    nl      = 1'b0;
    bottom  = 1'b0;
    home    = 1'b0;
    nl_req  = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          case (in_data)
            CHAR_CR: cr = 1'b1;
            CHAR_LF: nl_req = 1'b1;
            CHAR_BS: begin
              // Step back first so PUT blanks the cell now under the cursor.
              if (cursor_col != '0) begin
                bs      = 1'b1;
                char_d  = BLANK;
                adv_d   = 1'b0;
                state_d = PUT;
              end
            end
            CHAR_FF: begin
              idx_d   = '0;
              state_d = CLEAR;
            end
            default: begin
              if (in_data >= 8'h20 && in_data <= 8'h7E) begin
                char_d  = in_data;
                adv_d   = 1'b1;
                state_d = PUT;
              end
            end
          endcase
        end
      end
      PUT: begin
        state_d = IDLE;
        if (adv_q) begin
          if (last_col) begin
            cr     = 1'b1;
            nl_req = 1'b1;
          end else begin
            adv = 1'b1;
          end
        end
      end
      CLEAR: begin
        idx_d = idx_q + addr_width'(1);
        if (idx_q == LAST_CELL) begin
          home    = 1'b1;
          state_d = IDLE;
        end
      end
`ifdef CONSOLE_SCROLL_EN
      SCR_RD: state_d = SCR_WR;
      SCR_WR: begin
        idx_d   = idx_q + addr_width'(1);
        state_d = (idx_q == LAST_COPY) ? SCR_CLR : SCR_RD;
      end
      SCR_CLR: begin
        idx_d = idx_q + addr_width'(1);
        if (idx_q == LAST_CELL) begin
          cr      = 1'b1;
          bottom  = 1'b1;
          state_d = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    if (nl_req) begin
      if (!last_row) begin
        nl = 1'b1;
      end else begin
`ifdef CONSOLE_SCROLL_EN
        idx_d   = '0;
        state_d = SCR_RD;
`else
        nl = 1'b1;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      char_q  <= '0;
      adv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      char_q  <= char_d;
      adv_q   <= adv_d;
    end
  end

  // RAM port decode; SCR_WR forwards the word read during the previous SCR_RD.
  always_comb begin
    ram_we   = 1'b0;
    ram_addr = cell_addr;
    ram_din  = '0;
    case (state_q)
      PUT: begin
        ram_we  = 1'b1;
        ram_din = data_width'(char_q);
      end
      CLEAR: begin
        ram_we   = 1'b1;
        ram_addr = idx_q;
        ram_din  = data_width'(BLANK);
      end
`ifdef CONSOLE_SCROLL_EN
      SCR_RD: ram_addr = idx_q + addr_width'(cols);
      SCR_WR: begin
        ram_we   = 1'b1;
        ram_addr = idx_q;
        ram_din  = ram_dout;
      end
      SCR_CLR: begin
        ram_we   = 1'b1;
        ram_addr = idx_q;
        ram_din  = data_width'(BLANK);
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_console_writer.sv
// Directed bench for console_writer at default geometry (40x30) with a
// registered-read RAM model and a write scoreboard (expected address/data).
// Handles both builds: with and without CONSOLE_SCROLL_EN.
module tb_console_writer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic        ram_we;
  logic [10:0] ram_addr;
  logic [7:0]  ram_din;
  logic [7:0]  ram_dout;
  logic [5:0]  cursor_col;
  logic [4:0]  cursor_row;
  logic        busy;

  always #5 clk = ~clk;

  console_writer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_din    (ram_din),
    .ram_dout   (ram_dout),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row),
    .busy       (busy)
  );

  // RAM model with one preload port driven by the stimulus.
  logic [7:0] mem [0:1199];
  logic       pl_en = 1'b0;
  logic [7:0] pl_dat = 8'h00;
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    else if (pl_en) mem[40] <= pl_dat;
    ram_dout <= mem[ram_addr];
  end

  typedef struct packed {
    logic [10:0] a;
    logic [7:0]  d;
  } wr_t;

  wr_t        sb[$];
  wr_t        mon_e;
  logic [7:0] exp_mem [0:1199];
  int checks = 0;
  int errors = 0;
  int busy_cnt = 0;
  int we_cnt = 0;
  int rdy_low_cnt = 0;
  logic sb_off = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int a, input logic [7:0] d);
    sb.push_back({11'(a), d});
    exp_mem[a] = d;
  endtask

  // Write monitor and activity counters.
  always @(negedge clk) begin
    if (rst_n) begin
      if (busy) busy_cnt++;
      if (!in_ready) rdy_low_cnt++;
      if (ram_we) begin
        we_cnt++;
        if (!sb_off) begin
          if (sb.size() == 0) begin
            chk("stray_we", 32'(ram_we), 32'd0);
          end else begin
            mon_e = sb.pop_front();
            chk("wr_addr", 32'(ram_addr), 32'(mon_e.a));
            chk("wr_data", 32'(ram_din), 32'(mon_e.d));
          end
        end
      end
    end
  end

  task automatic clr_cnt();
    @(posedge clk);
    #1;
    busy_cnt = 0;
    we_cnt = 0;
    rdy_low_cnt = 0;
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    for (int i = 0; i < 5000 && !in_ready; i++) @(negedge clk);
    chk("send_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic chk_cur(input string tag, input int c, input int r);
    chk({tag, "_col"}, 32'(cursor_col), 32'(c));
    chk({tag, "_row"}, 32'(cursor_row), 32'(r));
  endtask

  initial begin
    // Reset state.
    #12;
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_we", 32'(ram_we), 32'd0);
    chk("rst_addr", 32'(ram_addr), 32'd0);
    chk("rst_din", 32'(ram_din), 32'd0);
    chk_cur("rst", 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single printable byte: one write, one cycle after accept.
    clr_cnt();
    push(0, 8'h41);
    send(8'h41);
    @(negedge clk);
    chk("put_we", 32'(ram_we), 32'd1);
    wait_idle();
    chk("a_we_cnt", 32'(we_cnt), 32'd1);
    chk_cur("a", 1, 0);

    // Full row from column 0 wraps to the next row.
    send(8'h0D);
    for (int i = 0; i < 40; i++) begin
      logic [7:0] ch;
      ch = 8'h61 + 8'(i % 26);
      push(i, ch);
      send(ch);
    end
    wait_idle();
    chk_cur("row", 0, 1);

    // Move to (5,3), then CR/LF and an ignored byte: no writes, always ready.
    send(8'h0A);
    send(8'h0A);
    for (int i = 0; i < 5; i++) begin
      push(120 + i, 8'h30 + 8'(i));
      send(8'h30 + 8'(i));
    end
    wait_idle();
    chk_cur("pos53", 5, 3);
    clr_cnt();
    send(8'h0D);
    send(8'h0A);
    send(8'h01);
    wait_idle();
    chk_cur("crlf", 0, 4);
    chk("crlf_we", 32'(we_cnt), 32'd0);
    chk("crlf_rdy_low", 32'(rdy_low_cnt), 32'd0);

    // Form feed: 1200 blank writes, busy 1200 cycles, cursor home.
    clr_cnt();
    for (int i = 0; i < 1200; i++) push(i, 8'h20);
    send(8'h0C);
    wait_idle();
    chk("ff_busy", 32'(busy_cnt), 32'd1200);
    chk("ff_we", 32'(we_cnt), 32'd1200);
    chk_cur("ff", 0, 0);

    // Backspace at column 0 is a no-op; at column 3 it blanks address 82.
    send(8'h0A);
    send(8'h0A);
    clr_cnt();
    send(8'h08);
    wait_idle();
    chk("bs0_we", 32'(we_cnt), 32'd0);
    chk_cur("bs0", 0, 2);
    push(80, 8'h78);
    send(8'h78);
    push(81, 8'h79);
    send(8'h79);
    push(82, 8'h7A);
    send(8'h7A);
    wait_idle();
    chk_cur("pos32", 3, 2);
    clr_cnt();
    push(82, 8'h20);
    send(8'h08);
    wait_idle();
    chk("bs3_we", 32'(we_cnt), 32'd1);
    chk_cur("bs3", 2, 2);

    // Walk to the last row and preload mem[40].
    for (int i = 0; i < 27; i++) send(8'h0A);
    wait_idle();
    chk_cur("row29", 2, 29);
    @(negedge clk);
    pl_en  = 1'b1;
    pl_dat = 8'h55;
    exp_mem[40] = 8'h55;
    @(negedge clk);
    pl_en = 1'b0;

    // Last-row newline.
    clr_cnt();
`ifdef CONSOLE_SCROLL_EN
    for (int i = 0; i < 1160; i++) push(i, exp_mem[i + 40]);
    for (int i = 1160; i < 1200; i++) push(i, 8'h20);
    send(8'h0A);
    wait_idle();
    chk("scr_busy", 32'(busy_cnt), 32'd2360);
    chk("scr_we", 32'(we_cnt), 32'd1200);
    chk("scr_mem0", 32'(exp_mem[0]), 32'h55);
    chk_cur("scr", 0, 29);
`else
    send(8'h0A);
    wait_idle();
    chk("wrap_busy", 32'(busy_cnt), 32'd0);
    chk("wrap_we", 32'(we_cnt), 32'd0);
    chk_cur("wrap", 2, 0);
    send(8'h0D);
    wait_idle();
    chk_cur("wrap_cr", 0, 0);
`endif
    chk("sb_empty", 32'(sb.size()), 32'd0);

    // Reset in the middle of a clear aborts to the reset state.
    send(8'h0A);
    sb_off = 1'b1;
    send(8'h0C);
    repeat (10) @(negedge clk);
    chk("mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_ready", 32'(in_ready), 32'd1);
    chk("abort_we", 32'(ram_we), 32'd0);
    chk_cur("abort", 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
